// File: rtl/zsram_array.sv
// zsram_array: WIDTH x DEPTH synchronous storage array driven by edge-detected
// write/read strobes. One-cycle registered read with write-first bypass, and an
// initialisation sequencer that clears every word after reset before Ready rises.
module zsram_array #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Crystal50Mhz,
    input  logic              Reset,
    input  logic              WriteEdge,
    input  logic [ADDR_W-1:0] WriteAddress,
    input  logic [WIDTH-1:0]  inputData,
    input  logic              ReadEdge,
    input  logic [ADDR_W-1:0] ReadAddress,
    output logic [WIDTH-1:0]  outputData,
    output logic              outputValid,
    output logic              Ready
);

    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  words [DEPTH];
    logic [0:0]        state;
    logic [ADDR_W-1:0] initCount;
    logic              WriteEdgeQ;
    logic              ReadEdgeQ;

    logic              writeReq;
    logic              readReq;
    logic              writeInRange;
    logic              readInRange;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [WIDTH-1:0]  memData;
    logic [WIDTH-1:0]  readData;

    assign writeInRange = ({1'b0, WriteAddress} < DEPTH_LIM);
    assign readInRange  = ({1'b0, ReadAddress} < DEPTH_LIM);

    // Requests are rising strobe edges, honoured only once initialisation is done
    assign writeReq = WriteEdge & ~WriteEdgeQ & (state == RUN);
    assign readReq  = ReadEdge  & ~ReadEdgeQ  & (state == RUN);

    assign Ready = (state == RUN);

    // Select the single array write port: init sequencer clears, otherwise user write
    always_comb begin
        memWe   = 1'b0;
        memAddr = '0;
        memData = '0;
        if (state == INIT) begin
            memWe   = 1'b1;
            memAddr = initCount;
            memData = '0;
        end else if (writeReq && writeInRange) begin
            memWe   = 1'b1;
            memAddr = WriteAddress;
            memData = inputData;
        end
    end

    // Read mux: out-of-range reads return zero, same-address write wins over stored word
    always_comb begin
        readData = '0;
        if (!readInRange) begin
            readData = '0;
        end else if (writeReq && (WriteAddress == ReadAddress)) begin
            readData = inputData;
        end else begin
            readData = words[ReadAddress];
        end
    end

    // Storage array; contents are only meaningful after the init sweep
    always_ff @(posedge Crystal50Mhz) begin
        if (memWe) begin
            words[memAddr] <= memData;
        end
    end

    // Control state, edge history and registered read output
    always_ff @(posedge Crystal50Mhz or posedge Reset) begin
        if (Reset) begin
            state       <= INIT;
            initCount   <= '0;
            WriteEdgeQ  <= 1'b0;
            ReadEdgeQ   <= 1'b0;
            outputData  <= '0;
            outputValid <= 1'b0;
        end else begin
            WriteEdgeQ  <= WriteEdge;
            ReadEdgeQ   <= ReadEdge;
            outputValid <= readReq;
            if (readReq) begin
                outputData <= readData;
            end
            if (state == INIT) begin
                if (initCount == LAST_ADDR) begin
                    state <= RUN;
                end else begin
                    initCount <= initCount + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/zsram_array.md
# zsram_array

Parametrised multi-word successor to the single zero-second RAM cell. A synchronous WIDTH x DEPTH storage array with edge-triggered write and read strobes, a one-cycle registered read, write-first collision bypass, and a self-clearing initialisation sequencer that zeroes every word after reset. It sits in the same digit-supply datapath as the single cell and replaces banks of individually wired cells.

## Interface
- WIDTH, 8, data word width in bits (>= 1)
- DEPTH, 16, number of words (>= 2, need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

- Crystal50Mhz  input  1  system clock, all state on rising edge
- Reset  input  1  asynchronous, active-high reset
- WriteEdge  input  1  write strobe level; a 0->1 transition requests one write
- WriteAddress  input  ADDR_W  write word index
- inputData  input  WIDTH  write data
- ReadEdge  input  1  read strobe level; a 0->1 transition requests one read
- ReadAddress  input  ADDR_W  read word index
- outputData  output  WIDTH  registered read data, held until next read
- outputValid  output  1  one-cycle pulse: outputData updated this cycle
- Ready  output  1  high when the array accepts requests (init finished)

## Operation
- Edge detection: registers WriteEdgeQ / ReadEdgeQ hold the previous-cycle strobe level. Write request = WriteEdge & ~WriteEdgeQ; read request likewise. A strobe held high produces exactly one request.
- States: INIT, RUN.
- INIT: InitCount runs 0..DEPTH-1, writing all-zero to word InitCount each cycle. After the cycle writing DEPTH-1: go to RUN and assert Ready. Requests detected in INIT are dropped, not queued. Edge registers keep tracking in INIT, so a strobe already high when Ready rises does not fire.
- RUN, write request: word[WriteAddress] <= inputData on that edge.
- RUN, read request: outputData <= word[ReadAddress], outputValid <= 1 for one cycle.
- Collision: write and read requests in the same cycle to the same address -> outputData returns the new inputData (write-first). Different addresses are independent.
- Out of range (address >= DEPTH, only when DEPTH is not a power of two): write ignored; read returns all-zero with outputValid still pulsed.
- Simultaneous requests on consecutive cycles: each request is serviced. Maximum rate is one read and one write per two cycles per strobe, because each needs a 0->1 edge.

## Timing
- Reset (async assert): state=INIT, InitCount=0, Ready=0, outputData=0, outputValid=0, WriteEdgeQ=ReadEdgeQ=0. Array contents are undefined until INIT completes.
- Reset deasserted before edge E0: words 0..DEPTH-1 are cleared at edges E0..E(DEPTH-1). Ready=1 after edge E(DEPTH-1); the first request is accepted at edge E(DEPTH).
- Reset mid-INIT or mid-RUN: immediate return to reset values. INIT restarts from word 0.
- Write latency: data is visible to a read request sampled at the same edge (bypass) or any later edge.
- Read latency: request sampled at edge N -> outputData and outputValid=1 after edge N. outputValid=0 after edge N+1 unless another read request is sampled at N+1.
- outputData changes only on a read request or reset.

## Test plan
- Reset, DEPTH=16: Ready stays 0 for 16 cycles and rises after the 16th edge. Read every address -> outputData=0x00 each time, with 16 outputValid pulses.
- Write 0xA5 to address 3 with WriteEdge held high for 5 cycles, then read address 3 -> exactly one write occurs, and the read returns 0xA5 one cycle after its edge.
- Same-cycle write 0x3C and read of address 7, where the old value is 0x11 -> outputData=0x3C, outputValid=1 for one cycle.
- Strobes pulsed during INIT, and ReadEdge held high across the Ready rise -> no write occurs, no outputValid pulse, and the array still reads all zero.
- DEPTH=10: write 0xFF to address 12, then read address 12 -> outputData=0x00 with outputValid pulsed. Address 9 is unaffected.
- Fill the array with address-pattern data, then assert Reset for one cycle mid-RUN -> outputs return to 0, Ready=0 for DEPTH cycles, and every word then reads 0.
